bnn_feature_loader: RTL and testbench
=====================================

Name: bnn_feature_loader

Overview:
- Sequential front-end for the combinational gasId BNN classifier (`features` in, `prediction` out).
- Accepts quantised features one per beat over a valid/ready stream and assembles the FEAT_CNT×FEAT_BITS feature vector.
- Drives the vector into the classifier, waits a fixed settle window, then captures `prediction` and returns it over a valid/ready result handshake.
- Replaces the bench-style "apply vector, wait period, sample" with synthesizable framing.

Parameters:
- FEAT_CNT, 128, features per frame.
- FEAT_BITS, 4, bits per feature.
- CLASS_CNT, 6, classifier classes; prediction width is $clog2(CLASS_CNT).
- SETTLE_CYCLES, 2, clock cycles the vector is held before the prediction is sampled; legal range ≥1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  loader can accept a beat.
- in_data  in  FEAT_BITS  one feature value.
- in_last  in  1  marks final beat of a frame.
- features  out  FEAT_CNT*FEAT_BITS  vector to classifier; feature k at bits [k*FEAT_BITS +: FEAT_BITS].
- prediction  in  $clog2(CLASS_CNT)  classifier output (combinational from features).
- out_valid  out  1  captured class valid.
- out_ready  in  1  downstream accepts class.
- out_class  out  $clog2(CLASS_CNT)  captured prediction.
- frame_err  out  1  one-cycle pulse: framing error, frame discarded.

Behaviour:
- Reset (rst high at an edge):
  - state←LOAD, beat counter←0, settle counter←0, features←0, out_class←0, out_valid←0, frame_err←0.
  - Reset overrides every other event in the same cycle, including mid-frame, SETTLE or OUT; partial frames and pending results are dropped.
- States: LOAD, SETTLE, OUT.
  - in_ready = (state==LOAD) && !rst, combinational.
- Beat acceptance: a beat is accepted at an edge where in_valid && in_ready.
- LOAD:
  - Accepted beat: features ← {in_data, features[top:FEAT_BITS]} (shift toward index 0), so the first beat of a frame ends at feature 0 and the FEAT_CNT-th at feature FEAT_CNT-1.
  - Beat counter width is $clog2(FEAT_CNT); it increments per accepted beat.
  - Accepted beat with count==FEAT_CNT-1 and in_last=1: counter←0, settle counter←0, state←SETTLE.
  - Framing error, either:
    - in_last=1 with count<FEAT_CNT-1, or
    - in_last=0 with count==FEAT_CNT-1.
  - On framing error: frame_err=1 for the following cycle, counter←0, state stays LOAD. features keeps the shifted value, but no result is produced.
- SETTLE:
  - in_ready=0; features held constant.
  - Settle counter increments each cycle.
  - At the edge where settle counter==SETTLE_CYCLES-1: out_class←prediction, out_valid←1, state←OUT.
  - Latency: last beat accepted at edge E → out_valid high from edge E+SETTLE_CYCLES.
- OUT:
  - out_valid=1, out_class stable, features still held.
  - Edge with out_ready=1: out_valid←0, state←LOAD.
  - out_ready may be held low indefinitely; no data is lost and no beats are accepted.
- Throughput with out_ready tied high: one result per FEAT_CNT+SETTLE_CYCLES+1 cycles.
- features changes only on accepted beats or reset; the captured class always corresponds to the complete frame just loaded.
- frame_err and out_valid are never both asserted for the same frame.

Test Plan:
- Single frame, feature k = k mod 16, classifier stub prediction = features[3:0] xor features[511:508] = 0 xor 15 = 15 mod 8 → 7 (3-bit). Expect:
  - out_valid exactly 2 cycles after the last-beat edge;
  - out_class=7;
  - features[3:0]=0 and features[511:508]=15.
- Back-to-back frames with in_valid always high and out_ready high: results every 131 cycles; in_ready low for exactly 3 cycles per frame.
- Backpressure: out_ready low for 20 cycles in OUT. Expect out_valid and out_class stable, in_ready=0, features unchanged; result released on the first out_ready-high edge.
- Early in_last on beat 50: frame_err pulses once, no out_valid; the next full 128-beat frame produces a correct class.
- Missing in_last on beat 127: frame_err pulses once; the counter restarts at 0.
- Reset asserted in LOAD at beat 70 and again during OUT. Expect:
  - all outputs at reset values next cycle;
  - no stale out_valid;
  - the next full frame is classified correctly.

Source files
------------

// File: rtl/bnn_feature_loader.sv
// Streaming front-end for the combinational BNN classifier: packs features beat by beat,
// holds the vector for a settle window, then returns the captured class over a handshake.
module bnn_feature_loader #(
  parameter int FEAT_CNT      = 128,
  parameter int FEAT_BITS     = 4,
  parameter int CLASS_CNT     = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FEAT_BITS-1:0]              in_data,
  input  logic                              in_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0]     features,
  input  logic [$clog2(CLASS_CNT)-1:0]      prediction,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]      out_class,
  output logic                              frame_err
);

  localparam int CW = $clog2(FEAT_CNT);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int FW = FEAT_CNT * FEAT_BITS;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] beat_cnt;
  logic [SW-1:0] settle_cnt;
  logic          beat;
  logic          last_slot;

  assign in_ready  = (state == ST_LOAD) && !rst;
  assign beat      = in_valid && in_ready;
  assign last_slot = (beat_cnt == CW'(FEAT_CNT - 1));

  // A frame is good only when in_last and the final slot coincide; either alone is a framing error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LOAD;
      beat_cnt   <= '0;
      settle_cnt <= '0;
      features   <= '0;
      out_class  <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (beat) begin
            features <= {in_data, features[FW-1:FEAT_BITS]};
            if (last_slot && in_last) begin
              beat_cnt   <= '0;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end else if (last_slot || in_last) begin
              beat_cnt  <= '0;
              frame_err <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            out_class <= prediction;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_feature_loader.sv
// Directed bench for bnn_feature_loader with a stub classifier: class = (feature0 ^ feature127) mod 8.
module tb_bnn_feature_loader;

  localparam int FEAT_CNT      = 128;
  localparam int FEAT_BITS     = 4;
  localparam int CLASS_CNT     = 6;
  localparam int SETTLE_CYCLES = 2;
  localparam int PW            = $clog2(CLASS_CNT);
  localparam int FW            = FEAT_CNT * FEAT_BITS;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_data;
  logic           in_last;
  logic [FW-1:0]  features;
  logic [PW-1:0]  prediction;
  logic           out_valid;
  logic           out_ready;
  logic [PW-1:0]  out_class;
  logic           frame_err;

  logic [FW-1:0]  exp_feat;
  logic [3:0]     pred_full;
  logic           out_valid_d = 1'b0;
  int             tests_run = 0;
  int             tests_failed = 0;
  int             cyc = 0;
  int             err_pulses = 0;
  int             rise_q[$];
  logic [PW-1:0]  class_q[$];

  bnn_feature_loader #(
    .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS),
    .CLASS_CNT(CLASS_CNT), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .features(features), .prediction(prediction),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  assign pred_full  = features[3:0] ^ features[FW-1:FW-4];
  assign prediction = pred_full[PW-1:0];

  always @(posedge clk) cyc++;

  // Records the cycle and class of every out_valid rise, and counts frame_err cycles.
  always @(negedge clk) begin
    if (out_valid && !out_valid_d) begin
      rise_q.push_back(cyc);
      class_q.push_back(out_class);
    end
    if (frame_err) err_pulses++;
    out_valid_d = out_valid;
  end

  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    exp_feat = '0;
    step();
    check_output({tag, "_out_valid"}, out_valid, 0);
    check_output({tag, "_out_class"}, out_class, 0);
    check_output({tag, "_frame_err"}, frame_err, 0);
    check_output({tag, "_features"}, |features, 0);
    check_output({tag, "_in_ready_rst"}, in_ready, 0);
    rst = 1'b0;
    #1;
    check_output({tag, "_in_ready"}, in_ready, 1);
  endtask

  // Presents one beat and holds it until the edge that accepts it; reports cycles spent waiting.
  task automatic drive_beat(input logic [3:0] d, input logic l, output int waits);
    waits = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    while (!in_ready && waits < 500) begin
      step();
      waits++;
    end
    if (!in_ready) check_output("beat_timeout", 0, 1);
    step();
    exp_feat = {d, exp_feat[FW-1:FEAT_BITS]};
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic apply_stimulus(input int mult, input int base, input int n, input int last_idx,
                                output int first_waits);
    int w;
    first_waits = 0;
    for (int k = 0; k < n; k++) begin
      drive_beat(4'((k * mult + base) % 16), (k == last_idx), w);
      if (k == 0) first_waits = w;
    end
  endtask

  task automatic wait_result(input string tag, input logic [PW-1:0] exp_class);
    int g = 0;
    while (!out_valid && g < 300) begin
      step();
      g++;
    end
    check_output({tag, "_valid"}, out_valid, 1);
    check_output({tag, "_class"}, out_class, exp_class);
    check_output({tag, "_feat"}, features == exp_feat, 1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int w0, w1, w2, err0, rise0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    exp_feat = '0;
    step();
    apply_reset("init");

    // Single frame, feature k = k mod 16: class (0 ^ 15) mod 8 = 7, two-cycle latency.
    apply_stimulus(1, 0, 128, 127, w0);
    check_output("lat_e0", out_valid, 0);
    step();
    check_output("lat_e1", out_valid, 0);
    step();
    check_output("lat_e2", out_valid, 1);
    check_output("single_class", out_class, 7);
    check_output("feat_lo", features[3:0], 0);
    check_output("feat_hi", features[FW-1:FW-4], 15);

    // Backpressure with in_valid held high: nothing moves for 20 cycles.
    in_valid = 1'b1;
    in_data = 4'hA;
    for (int i = 0; i < 20; i++) begin
      step();
      check_output("bp_valid", out_valid, 1);
      check_output("bp_class", out_class, 7);
      check_output("bp_in_ready", in_ready, 0);
      check_output("bp_feat", features == exp_feat, 1);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_output("bp_release_valid", out_valid, 0);
    check_output("bp_release_ready", in_ready, 1);

    // Back-to-back frames, out_ready high: classes 5, 3, 5 spaced 131 cycles apart.
    rise_q.delete();
    class_q.delete();
    apply_stimulus(3, 4, 128, 127, w0);
    apply_stimulus(7, 1, 128, 127, w1);
    apply_stimulus(3, 4, 128, 127, w2);
    for (int i = 0; i < 6; i++) step();
    check_output("b2b_first_wait", w0, 0);
    check_output("b2b_gap1", w1, 3);
    check_output("b2b_gap2", w2, 3);
    check_output("b2b_results", rise_q.size(), 3);
    if (rise_q.size() >= 3) begin
      check_output("b2b_period1", rise_q[1] - rise_q[0], 131);
      check_output("b2b_period2", rise_q[2] - rise_q[1], 131);
      check_output("b2b_class0", class_q[0], 5);
      check_output("b2b_class1", class_q[1], 3);
      check_output("b2b_class2", class_q[2], 5);
    end
    out_ready = 1'b0;

    // Early in_last on beat 50.
    err0 = err_pulses;
    rise0 = rise_q.size();
    apply_stimulus(1, 0, 50, 49, w0);
    check_output("early_err", frame_err, 1);
    step();
    check_output("early_err_drop", frame_err, 0);
    for (int i = 0; i < 8; i++) step();
    check_output("early_err_count", err_pulses - err0, 1);
    check_output("early_no_result", rise_q.size(), rise0);
    check_output("early_in_ready", in_ready, 1);
    apply_stimulus(7, 1, 128, 127, w0);
    wait_result("after_early", 3);
    release_result();

    // Missing in_last on beat 127; the following frame proves the counter restarted.
    err0 = err_pulses;
    rise0 = rise_q.size();
    apply_stimulus(3, 4, 128, -1, w0);
    check_output("miss_err", frame_err, 1);
    step();
    check_output("miss_err_drop", frame_err, 0);
    check_output("miss_err_count", err_pulses - err0, 1);
    check_output("miss_no_result", rise_q.size(), rise0);
    apply_stimulus(1, 0, 128, 127, w0);
    wait_result("after_miss", 7);
    release_result();

    // Reset mid-frame at beat 70, then again while a result is pending.
    apply_stimulus(1, 0, 70, -1, w0);
    apply_reset("rst_load");
    apply_stimulus(3, 4, 128, 127, w0);
    wait_result("pre_rst_out", 5);
    apply_reset("rst_out");
    rise0 = rise_q.size();
    for (int i = 0; i < 4; i++) step();
    check_output("no_stale_valid", out_valid, 0);
    check_output("no_stale_rise", rise_q.size(), rise0);
    apply_stimulus(7, 1, 128, 127, w0);
    wait_result("after_rst", 3);
    release_result();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
